// File: rtl/armv8_pkg.sv
// Shared ARMv8 register-file constants and the write-back queue entry type.
package armv8_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 64;
    localparam logic [REG_AW-1:0] XZR_ADDR = 5'd31;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [REG_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular write-back buffer: two enqueue ports (a older than b), one
// unconditional pop per cycle while non-empty, per-entry valid export.
module wb_fifo
    import armv8_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_a,
    input  wb_entry_t               entry_a,
    input  logic                    push_b,
    input  wb_entry_t               entry_b,
    output wb_entry_t [DEPTH-1:0]   entries,
    output logic [DEPTH-1:0]        valid,
    output logic [$clog2(DEPTH)-1:0] rd_ptr,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    dropped
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_ptr_b;
    logic [CW-1:0] n_enq;
    logic          deq;
    logic          take_a;
    logic          take_b;
    int            space;

    // The slot popped this edge is reusable, so a full buffer still takes one entry.
    always_comb begin
        deq      = (count != '0);
        space    = DEPTH - int'(count) + int'(deq);
        take_a   = push_a && (space >= 1);
        take_b   = push_b && (space >= (take_a ? 2 : 1));
        dropped  = (push_a && !take_a) || (push_b && !take_b);
        n_enq    = CW'(take_a) + CW'(take_b);
        wr_ptr_b = wr_ptr + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_enq);
            rd_ptr <= rd_ptr + PW'(deq);
            count  <= count + n_enq - CW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && take_a) begin
            mem[wr_ptr] <= entry_a;
        end
        if (!rst && take_b) begin
            mem[take_a ? wr_ptr_b : wr_ptr] <= entry_b;
        end
    end

    always_comb begin
        logic [PW-1:0] age;
        age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age      = PW'(i) - rd_ptr;
            valid[i] = ({1'b0, age} < count);
        end
    end

    assign entries = mem;

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port master: queues ALU/load results, drains one per cycle,
// flags pending-write hazards. Define WB_FORWARD_EN to forward the youngest pending data.
module wb_write_arbiter
    import armv8_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = REG_DW,
    parameter int AW    = REG_AW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_memValid,
    input  logic [AW-1:0] i_memRd,
    input  logic [DW-1:0] i_memData,
    input  logic          i_aluValid,
    input  logic [AW-1:0] i_aluRd,
    input  logic [DW-1:0] i_aluData,
    output logic          o_stall,
    output logic          o_overflow,
    output logic          o_regWr,
    output logic [AW-1:0] o_rd,
    output logic [DW-1:0] o_dataWr,
    input  logic [AW-1:0] i_rn,
    input  logic [AW-1:0] i_rm,
    output logic          o_hazRn,
    output logic          o_hazRm,
    output logic [DW-1:0] o_fwdRn,
    output logic [DW-1:0] o_fwdRm
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t [DEPTH-1:0] entries;
    wb_entry_t             entry_mem;
    wb_entry_t             entry_alu;
    wb_entry_t             head;
    logic [DEPTH-1:0]      valid;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  dropped;
    logic                  push_mem;
    logic                  push_alu;
    logic                  overflow;

    assign push_mem  = i_memValid && (i_memRd != XZR_ADDR);
    assign push_alu  = i_aluValid && (i_aluRd != XZR_ADDR);
    assign entry_mem = '{rd: i_memRd, data: i_memData};
    assign entry_alu = '{rd: i_aluRd, data: i_aluData};

    // The load is the older instruction, so it takes the first slot.
    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .push_a  (push_mem),
        .entry_a (entry_mem),
        .push_b  (push_alu),
        .entry_b (entry_alu),
        .entries (entries),
        .valid   (valid),
        .rd_ptr  (rd_ptr),
        .count   (count),
        .dropped (dropped)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overflow <= 1'b0;
        end else if (dropped) begin
            overflow <= 1'b1;
        end
    end

    assign head       = entries[rd_ptr];
    assign o_regWr    = (count != '0);
    assign o_rd       = o_regWr ? head.rd : '0;
    assign o_dataWr   = o_regWr ? head.data : '0;
    assign o_stall    = (count > CW'(DEPTH - 2));
    assign o_overflow = overflow;

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        o_hazRn = 1'b0;
        o_hazRm = 1'b0;
        o_fwdRn = '0;
        o_fwdRm = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (valid[idx] && (entries[idx].rd == i_rn) && (i_rn != XZR_ADDR)) begin
                o_hazRn = 1'b1;
`ifdef WB_FORWARD_EN
                o_fwdRn = entries[idx].data;
`endif
            end
            if (valid[idx] && (entries[idx].rd == i_rm) && (i_rm != XZR_ADDR)) begin
                o_hazRm = 1'b1;
`ifdef WB_FORWARD_EN
                o_fwdRm = entries[idx].data;
`endif
            end
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter (DEPTH=4); forward
// expectations follow WB_FORWARD_EN.
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [63:0] mem_data;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        stall;
    logic        overflow;
    logic        reg_wr;
    logic [4:0]  rd;
    logic [63:0] data_wr;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic        haz_rn;
    logic        haz_rm;
    logic [63:0] fwd_rn;
    logic [63:0] fwd_rm;

    int checks   = 0;
    int failures = 0;

`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    wb_write_arbiter #(
        .DEPTH (4),
        .DW    (64),
        .AW    (5)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_memValid (mem_valid),
        .i_memRd    (mem_rd),
        .i_memData  (mem_data),
        .i_aluValid (alu_valid),
        .i_aluRd    (alu_rd),
        .i_aluData  (alu_data),
        .o_stall    (stall),
        .o_overflow (overflow),
        .o_regWr    (reg_wr),
        .o_rd       (rd),
        .o_dataWr   (data_wr),
        .i_rn       (rn),
        .i_rm       (rm),
        .o_hazRn    (haz_rn),
        .o_hazRm    (haz_rm),
        .o_fwdRn    (fwd_rn),
        .o_fwdRm    (fwd_rm)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] fwd_exp(input logic [63:0] v);
        return FWD ? v : 64'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mv, input logic [4:0] mrd, input logic [63:0] md,
                         input logic av, input logic [4:0] ard, input logic [63:0] ad);
        mem_valid = mv;
        mem_rd    = mrd;
        mem_data  = md;
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        rn  = 5'd0;
        rm  = 5'd0;
        idle();
        tick();
        tick();
        check("rst_regwr", 64'(reg_wr), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_hazrn", 64'(haz_rn), 64'd0);
        check("rst_hazrm", 64'(haz_rm), 64'd0);
        check("rst_fwdrn", fwd_rn, 64'd0);
        rst = 1'b0;

        // Single ALU write is presented for exactly one cycle
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 64'hAA);
        tick();
        check("alu_regwr", 64'(reg_wr), 64'd1);
        check("alu_rd", 64'(rd), 64'd3);
        check("alu_data", data_wr, 64'hAA);
        idle();
        tick();
        check("alu_done", 64'(reg_wr), 64'd0);

        // Dual enqueue: load drains before ALU
        drive(1'b1, 5'd5, 64'h11, 1'b1, 5'd6, 64'h22);
        rn = 5'd6;
        tick();
        check("dual_rd0", 64'(rd), 64'd5);
        check("dual_data0", data_wr, 64'h11);
        check("dual_haz6", 64'(haz_rn), 64'd1);
        check("dual_fwd6", fwd_rn, fwd_exp(64'h22));
        check("dual_stall", 64'(stall), 64'd0);
        idle();
        tick();
        check("dual_regwr1", 64'(reg_wr), 64'd1);
        check("dual_rd1", 64'(rd), 64'd6);
        check("dual_data1", data_wr, 64'h22);
        tick();
        check("dual_empty", 64'(reg_wr), 64'd0);
        check("dual_nohaz", 64'(haz_rn), 64'd0);

        // XZR write is discarded
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'hFF);
        rn = 5'd31;
        tick();
        check("xzr_regwr", 64'(reg_wr), 64'd0);
        check("xzr_haz", 64'(haz_rn), 64'd0);
        idle();
        tick();
        check("xzr_regwr2", 64'(reg_wr), 64'd0);

        // Two pending writes to r7 behind a backlog: youngest wins
        drive(1'b1, 5'd9, 64'h9, 1'b1, 5'd10, 64'h10);
        rn = 5'd7;
        rm = 5'd10;
        tick();
        check("yng_haz7_pre", 64'(haz_rn), 64'd0);
        check("yng_haz10", 64'(haz_rm), 64'd1);
        check("yng_fwd10", fwd_rm, fwd_exp(64'h10));
        drive(1'b1, 5'd7, 64'd1, 1'b1, 5'd7, 64'd2);
        tick();
        check("yng_stall", 64'(stall), 64'd1);
        check("yng_haz7", 64'(haz_rn), 64'd1);
        check("yng_fwd7", fwd_rn, fwd_exp(64'd2));
        check("yng_head10", 64'(rd), 64'd10);
        idle();
        tick();
        check("yng_head7a", 64'(rd), 64'd7);
        check("yng_data7a", data_wr, 64'd1);
        check("yng_fwd7b", fwd_rn, fwd_exp(64'd2));
        check("yng_stall_off", 64'(stall), 64'd0);
        check("yng_haz10_gone", 64'(haz_rm), 64'd0);
        tick();
        check("yng_data7b", data_wr, 64'd2);
        tick();
        check("yng_empty", 64'(reg_wr), 64'd0);
        check("yng_nohaz", 64'(haz_rn), 64'd0);
        check("yng_nofwd", fwd_rn, 64'd0);
        rm = 5'd0;

        // Burst fill and overflow
        drive(1'b1, 5'd1, 64'h101, 1'b1, 5'd2, 64'h102);
        tick();
        check("bst1_stall", 64'(stall), 64'd0);
        check("bst1_rd", 64'(rd), 64'd1);
        drive(1'b1, 5'd3, 64'h103, 1'b1, 5'd4, 64'h104);
        tick();
        check("bst2_stall", 64'(stall), 64'd1);
        check("bst2_rd", 64'(rd), 64'd2);
        drive(1'b1, 5'd8, 64'h108, 1'b1, 5'd11, 64'h10B);
        tick();
        check("bst3_stall", 64'(stall), 64'd1);
        check("bst3_ovf", 64'(overflow), 64'd0);
        check("bst3_rd", 64'(rd), 64'd3);
        drive(1'b1, 5'd12, 64'h10C, 1'b1, 5'd13, 64'h10D);
        rn = 5'd13;
        rm = 5'd12;
        tick();
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_rd", 64'(rd), 64'd4);
        check("ovf_data", data_wr, 64'h104);
        check("ovf_alu_dropped", 64'(haz_rn), 64'd0);
        check("ovf_mem_kept", 64'(haz_rm), 64'd1);
        check("ovf_fwd12", fwd_rm, fwd_exp(64'h10C));
        idle();
        tick();
        check("ovf_sticky", 64'(overflow), 64'd1);
        check("ovf_stall3", 64'(stall), 64'd1);
        check("ovf_rd8", 64'(rd), 64'd8);

        // Reset mid-drain with three entries queued
        rn  = 5'd11;
        rst = 1'b1;
        tick();
        check("mrst_regwr", 64'(reg_wr), 64'd0);
        check("mrst_stall", 64'(stall), 64'd0);
        check("mrst_ovf", 64'(overflow), 64'd0);
        check("mrst_hazrn", 64'(haz_rn), 64'd0);
        check("mrst_hazrm", 64'(haz_rm), 64'd0);
        check("mrst_fwdrn", fwd_rn, 64'd0);
        rst = 1'b0;
        tick();
        check("mrst_regwr1", 64'(reg_wr), 64'd0);
        tick();
        check("mrst_regwr2", 64'(reg_wr), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
